// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
//   Bundles the byte stream coming from the PS/2 receiver and the decoded key
//   event / game-key outputs of ps2_key_decoder.
//   Signals:
//     scan_valid  one-cycle strobe, a received byte is present
//     scan_code   received byte (valid with scan_valid)
//     key_valid   one-cycle strobe, completed key event
//     key_code    final code byte of the event, prefixes stripped
//     key_ext     event was E0-prefixed
//     key_break   event is a release
//     held        level per game key
//     press       one-cycle pulse on a fresh press of a game key
//   Modports:
//     master  byte source / event consumer side
//     slave   decoder side
interface ps2_key_decoder_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [4:0] held;
  logic [4:0] press;

  modport master (
    output scan_valid, scan_code,
    input  key_valid, key_code, key_ext, key_break, held, press
  );

  modport slave (
    input  scan_valid, scan_code,
    output key_valid, key_code, key_ext, key_break, held, press
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
//   Assembles PS/2 Set-2 scan-code bytes into key events (make/break,
//   extended flag, code byte) and tracks held levels plus auto-repeat
//   filtered press pulses for five game-control keys. The Pause (E1)
//   sequence and keyboard status bytes are discarded, and a pending prefix
//   is abandoned after TIMEOUT_CYCLES cycles without a byte.
//   Ports:
//     clk    system clock
//     reset  synchronous active-low reset
//     bus    ps2_key_decoder_if.slave (scan byte in, key event / game keys out)
//   Game key bit map: [0] left E0 6B, [1] right E0 74, [2] down E0 72,
//                     [3] rotate E0 75, [4] drop 29 (not extended)
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } state_t;

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] GAME_CODE [0:4] = '{8'h6B, 8'h74, 8'h72, 8'h75, 8'h29};
  localparam logic [4:0] GAME_EXT        = 5'b01111;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       skip_reg, skip_next;

  logic             key_valid_reg;
  logic [7:0]       key_code_reg;
  logic             key_ext_reg;
  logic             key_break_reg;
  logic [4:0]       held_reg, held_next;
  logic [4:0]       press_reg, press_next;

  logic             emit;
  logic             emit_ext;
  logic             emit_break;
  logic [4:0]       hit;

  // Keyboard acknowledgement / status bytes that never start a key event.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_status = 1'b1;
      default:                                          is_status = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      skip_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    skip_next  = skip_reg;
    emit       = 1'b0;
    emit_ext   = 1'b0;
    emit_break = 1'b0;

    if (bus.scan_valid) begin
      // A byte always wins over a coinciding timeout expiry.
      case (state_reg)
        IDLE: begin
          if (bus.scan_code == 8'hE0) begin
            state_next = EXT;
          end else if (bus.scan_code == 8'hF0) begin
            state_next = BRK;
          end else if (bus.scan_code == 8'hE1) begin
            state_next = SKIP;
            skip_next  = 3'd7;
          end else if (!is_status(bus.scan_code)) begin
            emit = 1'b1;
          end
        end
        EXT: begin
          if (bus.scan_code == 8'hF0) begin
            state_next = EXT_BRK;
          end else if (bus.scan_code != 8'hE0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            state_next = IDLE;
          end
        end
        BRK: begin
          if (bus.scan_code != 8'hF0) begin
            emit       = 1'b1;
            emit_break = 1'b1;
            state_next = IDLE;
          end
        end
        EXT_BRK: begin
          if (bus.scan_code != 8'hF0) begin
            emit       = 1'b1;
            emit_ext   = 1'b1;
            emit_break = 1'b1;
            state_next = IDLE;
          end
        end
        SKIP: begin
          // Pause is E1 followed by seven more bytes, all swallowed.
          skip_next = skip_reg - 3'd1;
          if (skip_reg == 3'd1) begin
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end else if (state_reg != IDLE) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = IDLE;
        skip_next  = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // A game key matches only when both the code and the extended flag agree.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_game_key
      assign hit[gi] = emit && (bus.scan_code == GAME_CODE[gi]) && (emit_ext == GAME_EXT[gi]);
    end
  endgenerate

  always_comb begin
    held_next  = held_reg;
    press_next = '0;
    if (emit_break) begin
      held_next = held_reg & ~hit;
    end else begin
      held_next  = held_reg | hit;
      // Typematic repeats arrive with the key already held: no new press.
      press_next = hit & ~held_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= 8'h00;
      key_ext_reg   <= 1'b0;
      key_break_reg <= 1'b0;
      held_reg      <= '0;
      press_reg     <= '0;
    end else begin
      key_valid_reg <= emit;
      if (emit) begin
        key_code_reg  <= bus.scan_code;
        key_ext_reg   <= emit_ext;
        key_break_reg <= emit_break;
      end
      held_reg  <= held_next;
      press_reg <= press_next;
    end
  end

  assign bus.key_valid = key_valid_reg;
  assign bus.key_code  = key_code_reg;
  assign bus.key_ext   = key_ext_reg;
  assign bus.key_break = key_break_reg;
  assign bus.held      = held_reg;
  assign bus.press     = press_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
//   Directed stimulus for ps2_key_decoder with a sequence-level reference
//   model checked on every cycle, plus literal expectations per scenario.
module tb_ps2_key_decoder;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic       exp_valid = 1'b0;
  logic [7:0] exp_code  = 8'h00;
  logic       exp_ext   = 1'b0;
  logic       exp_brk   = 1'b0;
  logic [4:0] exp_held  = '0;
  logic [4:0] exp_press = '0;

  bit m_ext_seen = 0;
  bit m_brk_seen = 0;
  int m_skip_left = 0;
  int m_gap = 0;

  int kv_count = 0;
  int press0_count = 0;
  int press4_count = 0;

  function automatic int game_index(input logic [7:0] code, input logic ext);
    case ({ext, code})
      {1'b1, 8'h6B}: return 0;
      {1'b1, 8'h74}: return 1;
      {1'b1, 8'h72}: return 2;
      {1'b1, 8'h75}: return 3;
      {1'b0, 8'h29}: return 4;
      default:       return -1;
    endcase
  endfunction

  task automatic model_emit(input logic [7:0] code, input logic ext, input logic brk);
    int idx;
    exp_valid = 1'b1;
    exp_code  = code;
    exp_ext   = ext;
    exp_brk   = brk;
    idx = game_index(code, ext);
    if (idx >= 0) begin
      if (brk) exp_held[idx] = 1'b0;
      else begin
        if (!exp_held[idx]) exp_press[idx] = 1'b1;
        exp_held[idx] = 1'b1;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_gap = 0;
    if (m_skip_left > 0) begin
      m_skip_left--;
    end else if (!m_ext_seen && !m_brk_seen) begin
      if (b == 8'hE0) m_ext_seen = 1;
      else if (b == 8'hF0) m_brk_seen = 1;
      else if (b == 8'hE1) m_skip_left = 7;
      else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF}))
        model_emit(b, 1'b0, 1'b0);
    end else begin
      if (b == 8'hF0) m_brk_seen = 1;
      else if (!(b == 8'hE0 && m_ext_seen && !m_brk_seen)) begin
        model_emit(b, m_ext_seen, m_brk_seen);
        m_ext_seen = 0;
        m_brk_seen = 0;
      end
    end
  endtask

  // Compare outputs produced by the last rising edge, then predict the next.
  always @(negedge clk) begin
    check("key_valid", bus.key_valid, exp_valid);
    check("key_code",  bus.key_code,  exp_code);
    check("key_ext",   bus.key_ext,   exp_ext);
    check("key_break", bus.key_break, exp_brk);
    check("held",      bus.held,      exp_held);
    check("press",     bus.press,     exp_press);
    kv_count     += int'(bus.key_valid);
    press0_count += int'(bus.press[0]);
    press4_count += int'(bus.press[4]);

    exp_valid = 1'b0;
    exp_press = '0;
    if (!reset) begin
      exp_code = 8'h00; exp_ext = 1'b0; exp_brk = 1'b0; exp_held = '0;
      m_ext_seen = 0; m_brk_seen = 0; m_skip_left = 0; m_gap = 0;
    end else if (bus.scan_valid) begin
      model_byte(bus.scan_code);
    end else if (m_ext_seen || m_brk_seen || m_skip_left > 0) begin
      m_gap++;
      if (m_gap >= TO) begin
        m_ext_seen = 0; m_brk_seen = 0; m_skip_left = 0; m_gap = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [7:0] b);
    bus.scan_valid = 1'b1;
    bus.scan_code  = b;
    @(posedge clk); #1;
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Settle to the negedge after the last edge so DUT outputs and counts are final.
  task automatic settle();
    @(negedge clk); #1;
  endtask

  int kv0;
  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

  initial begin
    bus.scan_valid = 1'b0;
    bus.scan_code  = 8'h00;
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset held for 2 cycles while bytes arrive.
    bus.scan_valid = 1'b1; bus.scan_code = 8'hE0;
    @(posedge clk); #1;
    bus.scan_code = 8'h1C;
    @(posedge clk); #1;
    bus.scan_valid = 1'b0;
    settle();
    check("rst_valid", bus.key_valid, 1'b0);
    check("rst_code",  bus.key_code,  8'h00);
    check("rst_held",  bus.held,      5'h00);
    reset = 1'b1;
    idle(1);

    // Plain make.
    kv0 = kv_count;
    send(8'h1C);
    settle();
    check("make1c_valid", bus.key_valid, 1'b1);
    check("make1c_code",  bus.key_code,  8'h1C);
    check("make1c_ext",   {bus.key_ext, bus.key_break}, 2'b00);
    check("make1c_press", bus.press, 5'h00);
    idle(1);

    // Extended left with a typematic repeat, then release.
    kv0 = kv_count;
    send(8'hE0); send(8'h6B); idle(2);
    send(8'hE0); send(8'h6B); idle(2);
    check("left_held", bus.held[0], 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    settle();
    check("left_brk",     {bus.key_ext, bus.key_break}, 2'b11);
    check("left_released", bus.held[0], 1'b0);
    check("left_events",  kv_count - kv0, 3);
    check("left_presses", press0_count, 1);
    idle(1);

    // Drop key back-to-back.
    kv0 = kv_count;
    send(8'h29); send(8'hF0); send(8'h29); idle(2);
    check("drop_events",  kv_count - kv0, 2);
    check("drop_presses", press4_count, 1);
    check("drop_held",    bus.held[4], 1'b0);

    // Pause sequence swallowed, then a normal make.
    kv0 = kv_count;
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    idle(2);
    check("pause_events", kv_count - kv0, 0);
    send(8'h1C);
    settle();
    check("after_pause_code", bus.key_code, 8'h1C);
    check("after_pause_events", kv_count - kv0, 1);
    idle(1);

    // Timeout: long gap abandons F0, so 6B is a make.
    send(8'hF0); idle(19); send(8'h6B);
    settle();
    check("to_long_break", {bus.key_valid, bus.key_break}, 2'b10);
    idle(1);
    // 6B at cycle 15 after F0: still a break.
    send(8'hF0); idle(14); send(8'h6B);
    settle();
    check("to_15_break", {bus.key_valid, bus.key_break}, 2'b11);
    idle(1);
    // Byte coinciding with expiry (cycle 16) wins.
    send(8'hF0); idle(15); send(8'h6B);
    settle();
    check("to_16_break", {bus.key_valid, bus.key_break}, 2'b11);
    idle(1);
    // One cycle later the prefix is gone.
    send(8'hF0); idle(16); send(8'h6B);
    settle();
    check("to_17_make", {bus.key_valid, bus.key_break}, 2'b10);
    idle(1);

    // Wrong ext flag for a mapped code leaves held alone; right one sets it.
    send(8'hE0); send(8'h29); idle(1);
    check("ext29_held", bus.held[4], 1'b0);
    send(8'hE0); send(8'h74);
    settle();
    check("right_press", bus.press, 5'b00010);
    idle(1);

    // Status bytes ignored, held unchanged.
    kv0 = kv_count;
    send(8'hAA); send(8'hFA); send(8'h00); idle(2);
    check("status_events", kv_count - kv0, 0);
    check("status_held",   bus.held, 5'b00010);

    // Reset mid-sequence discards it.
    send(8'hE0);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    kv0 = kv_count;
    send(8'h74); idle(1);
    check("mid_rst_ext", bus.key_ext, 1'b0);
    check("mid_rst_held", bus.held, 5'b00000);

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Consumes the byte stream from the PS/2 receiver (one byte per rx_done_tick) and assembles Set-2 scan-code sequences into key events: make/break, extended flag and 8-bit code.
- Maintains held levels and auto-repeat-filtered press pulses for the five game-control keys consumed by the block-stacking game logic.
- Discards the Pause (E1) sequence and keyboard status bytes.
- Recovers from truncated prefixes via an inactivity timeout.

Parameters:
- TIMEOUT_CYCLES, 2000000, clk cycles with no byte while a prefix is pending before abandoning it (20 ms at 100 MHz); minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
- scan_valid  in  1  one-cycle strobe, byte available (driven by receiver rx_done_tick)
- scan_code  in  8  received byte, valid only when scan_valid=1
- key_valid  out  1  one-cycle strobe, completed key event
- key_code  out  8  final code byte of the event (prefixes stripped)
- key_ext  out  1  1 = E0-prefixed key
- key_break  out  1  1 = release, 0 = press
- held  out  5  level per game key: [0] left (E0 6B), [1] right (E0 74), [2] down (E0 72), [3] rotate/up (E0 75), [4] drop/space (29, non-ext)
- press  out  5  one-cycle pulse on make of a game key whose held bit was 0 (same bit map)

Behaviour:
- Reset (reset=0 at clk edge): state IDLE, timeout counter 0, skip counter 0, key_valid=0, key_code=8'h00, key_ext=0, key_break=0, held=0, press=0. Reset mid-sequence discards the partial sequence; no event is emitted.
- All outputs are registered. key_valid and press assert exactly one cycle after the scan_valid cycle carrying the final byte. held updates on that same cycle. key_code/ext/break hold their value until the next event.
- FSM, evaluated only when scan_valid=1:
  - IDLE:
    - E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip count 7.
    - FA, AA, EE, FE, FC, 00, FF -> ignored, stay IDLE.
    - Any other byte -> emit make (ext=0), stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; any other byte -> emit make (ext=1), go IDLE.
  - BRK: F0 -> stay BRK; any other byte -> emit break (ext=0), go IDLE.
  - EXT_BRK: F0 -> stay; any other byte -> emit break (ext=1), go IDLE.
  - SKIP: decrement skip count per byte, no events. When the count reaches 0 after the 7th byte, go IDLE. Total Pause sequence is 8 bytes.
- Game-key logic on each emitted event matching a mapped key:
  - Make: set held bit. press bit pulses only if held was 0, so typematic repeats produce key_valid but no press.
  - Break: clear held bit, no press.
  - Unmapped keys, and mapped codes with the wrong ext flag (e.g. 6B without E0), leave held/press unchanged.
- Timeout:
  - Counter runs only in EXT, BRK, EXT_BRK and SKIP. It clears on every scan_valid and on entry to IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with scan_valid=0, the next state is IDLE, with no event and held unchanged.
  - If scan_valid coincides with expiry, the byte wins and is processed in the current state.
- scan_valid for consecutive cycles is legal: each byte is processed in order, one per cycle.

Test Plan:
- reset=0 for 2 cycles with scan_valid pulses -> all outputs 0; after release, byte 1C -> key_valid one cycle later, key_code=1C, ext=0, break=0, press=0.
- Bytes E0, 6B, E0, 6B (typematic), E0, F0, 6B -> two key_valid make events with ext=1. press[0] pulses once, on the first event only. held[0]=1 until the break event, then 0 with break=1.
- Bytes 29, F0, 29 back-to-back on consecutive cycles -> press[4] pulse, then break event; held[4] ends 0; exactly 2 key_valid pulses.
- Bytes E1, 14, 77, E1, F0, 14, F0, 77, then 1C -> no key_valid for the first 8 bytes; 1C produces a make event.
- TIMEOUT_CYCLES=16: byte F0, 20 idle cycles, byte 6B -> make event (break=0), not break; repeat with 6B at cycle 15 after F0 -> break event.
- Bytes AA, FA, 00 -> no key_valid; held unchanged.
